// File: rtl/dram_init_seq.sv
// DRAM power-up sequencer: holds CKE low, raises it, then issues PRECHARGE-ALL,
// EMRS, MRS and N_REF REFRESH commands over valid/ready before flagging done.
module dram_init_seq #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned PWRUP_CYC = 400,
  parameter int unsigned TXPR_CYC  = 20,
  parameter int unsigned TRP_CYC   = 4,
  parameter int unsigned TMRD_CYC  = 2,
  parameter int unsigned TRFC_CYC  = 26,
  parameter int unsigned N_REF     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_start,
  input  logic       cmd_ready,
  output logic       cke_data,
  output logic       cmd_vld,
  output logic [2:0] cmd_code,
  output logic       init_busy,
  output logic       init_done
);

  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  if (PWRUP_CYC > CNT_MAX || TXPR_CYC > CNT_MAX || TRP_CYC > CNT_MAX ||
      TMRD_CYC > CNT_MAX || TRFC_CYC > CNT_MAX) begin : g_cnt_fit_chk
    $error("dram_init_seq: a wait parameter does not fit in CNT_W bits");
  end
  if (N_REF < 1 || N_REF > 15) begin : g_nref_chk
    $error("dram_init_seq: N_REF must be in 1..15");
  end

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PWRUP    = 4'd1,
    S_CKE_WAIT = 4'd2,
    S_ISS_PRE  = 4'd3,
    S_W_RP     = 4'd4,
    S_ISS_EMRS = 4'd5,
    S_W_MRD    = 4'd6,
    S_ISS_MRS  = 4'd7,
    S_W_MRD2   = 4'd8,
    S_ISS_REF  = 4'd9,
    S_W_RFC    = 4'd10,
    S_DONE     = 4'd11
  } state_t;

  localparam logic [2:0] CMD_NONE = 3'b000;
  localparam logic [2:0] CMD_PRE  = 3'b001;
  localparam logic [2:0] CMD_EMRS = 3'b010;
  localparam logic [2:0] CMD_MRS  = 3'b011;
  localparam logic [2:0] CMD_REF  = 3'b100;

  // Zero-length waits collapse to one cycle: load value is max(n,1)-1.
  function automatic logic [CNT_W-1:0] wait_ld(input int unsigned n);
    if (n == 32'd0) wait_ld = '0;
    else            wait_ld = CNT_W'(n - 32'd1);
  endfunction

  localparam logic [CNT_W-1:0] LD_PWRUP = wait_ld(PWRUP_CYC);
  localparam logic [CNT_W-1:0] LD_TXPR  = wait_ld(TXPR_CYC);
  localparam logic [CNT_W-1:0] LD_TRP   = wait_ld(TRP_CYC);
  localparam logic [CNT_W-1:0] LD_TMRD  = wait_ld(TMRD_CYC);
  localparam logic [CNT_W-1:0] LD_TRFC  = wait_ld(TRFC_CYC);
  localparam logic [3:0]       NREF_4   = 4'(N_REF);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       ref_q, ref_d;
  logic             cnt_zero_s;
  logic             cke_d, vld_d, busy_d, done_d;
  logic [2:0]       code_d;

  assign cnt_zero_s = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (init_start) begin
          state_d = S_PWRUP;
          cnt_d   = LD_PWRUP;
          ref_d   = 4'd0;
        end
      end
      S_PWRUP: begin
        if (cnt_zero_s) begin
          state_d = S_CKE_WAIT;
          cnt_d   = LD_TXPR;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CKE_WAIT: begin
        if (cnt_zero_s) state_d = S_ISS_PRE;
        else            cnt_d   = cnt_q - 1'b1;
      end
      S_ISS_PRE: begin
        if (cmd_ready) begin
          state_d = S_W_RP;
          cnt_d   = LD_TRP;
        end
      end
      S_W_RP: begin
        if (cnt_zero_s) state_d = S_ISS_EMRS;
        else            cnt_d   = cnt_q - 1'b1;
      end
      S_ISS_EMRS: begin
        if (cmd_ready) begin
          state_d = S_W_MRD;
          cnt_d   = LD_TMRD;
        end
      end
      S_W_MRD: begin
        if (cnt_zero_s) state_d = S_ISS_MRS;
        else            cnt_d   = cnt_q - 1'b1;
      end
      S_ISS_MRS: begin
        if (cmd_ready) begin
          state_d = S_W_MRD2;
          cnt_d   = LD_TMRD;
        end
      end
      S_W_MRD2: begin
        if (cnt_zero_s) state_d = S_ISS_REF;
        else            cnt_d   = cnt_q - 1'b1;
      end
      S_ISS_REF: begin
        if (cmd_ready) begin
          state_d = S_W_RFC;
          cnt_d   = LD_TRFC;
          ref_d   = ref_q + 4'd1;
        end
      end
      S_W_RFC: begin
        if (!cnt_zero_s)         cnt_d   = cnt_q - 1'b1;
        else if (ref_q < NREF_4) state_d = S_ISS_REF;
        else                     state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        ref_d   = 4'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    cke_d  = 1'b0;
    vld_d  = 1'b0;
    code_d = CMD_NONE;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_IDLE:     ;
      S_PWRUP:    busy_d = 1'b1;
      S_CKE_WAIT, S_W_RP, S_W_MRD, S_W_MRD2, S_W_RFC: begin
        cke_d  = 1'b1;
        busy_d = 1'b1;
      end
      S_ISS_PRE:  begin cke_d = 1'b1; busy_d = 1'b1; vld_d = 1'b1; code_d = CMD_PRE;  end
      S_ISS_EMRS: begin cke_d = 1'b1; busy_d = 1'b1; vld_d = 1'b1; code_d = CMD_EMRS; end
      S_ISS_MRS:  begin cke_d = 1'b1; busy_d = 1'b1; vld_d = 1'b1; code_d = CMD_MRS;  end
      S_ISS_REF:  begin cke_d = 1'b1; busy_d = 1'b1; vld_d = 1'b1; code_d = CMD_REF;  end
      S_DONE:     begin cke_d = 1'b1; done_d = 1'b1; end
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ref_q     <= 4'd0;
      cke_data  <= 1'b0;
      cmd_vld   <= 1'b0;
      cmd_code  <= CMD_NONE;
      init_busy <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_q     <= ref_d;
      cke_data  <= cke_d;
      cmd_vld   <= vld_d;
      cmd_code  <= code_d;
      init_busy <= busy_d;
      init_done <= done_d;
    end
  end

endmodule

// File: tb/tb_dram_init_seq.sv
// Directed bench for dram_init_seq: acceptance cycles, CKE rise and done timing
// under no stall, backpressure, ignored starts, reset abort, re-init and zero waits.
module tb_dram_init_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_start = 1'b0;
  logic cmd_ready = 1'b1;
  bit   sel = 1'b0;

  logic       n_cke, n_vld, n_busy, n_done;
  logic [2:0] n_code;
  logic       z_cke, z_vld, z_busy, z_done;
  logic [2:0] z_code;
  logic       n_start, z_start;

  logic       o_cke, o_vld, o_busy, o_done;
  logic [2:0] o_code;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  assign n_start = init_start & ~sel;
  assign z_start = init_start & sel;

  assign o_cke  = sel ? z_cke  : n_cke;
  assign o_vld  = sel ? z_vld  : n_vld;
  assign o_busy = sel ? z_busy : n_busy;
  assign o_done = sel ? z_done : n_done;
  assign o_code = sel ? z_code : n_code;

  dram_init_seq #(.CNT_W(16), .PWRUP_CYC(8), .TXPR_CYC(4), .TRP_CYC(3),
                  .TMRD_CYC(2), .TRFC_CYC(5), .N_REF(2)) dut (
    .clk(clk), .rst(rst), .init_start(n_start), .cmd_ready(cmd_ready),
    .cke_data(n_cke), .cmd_vld(n_vld), .cmd_code(n_code),
    .init_busy(n_busy), .init_done(n_done));

  dram_init_seq #(.CNT_W(16), .PWRUP_CYC(8), .TXPR_CYC(4), .TRP_CYC(0),
                  .TMRD_CYC(0), .TRFC_CYC(5), .N_REF(2)) dut_z (
    .clk(clk), .rst(rst), .init_start(z_start), .cmd_ready(cmd_ready),
    .cke_data(z_cke), .cmd_vld(z_vld), .cmd_code(z_code),
    .init_busy(z_busy), .init_done(z_done));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts a sequence and follows it to done, stalling each issue for `stall`
  // cycles and pulsing init_start during cycles ign_a/ign_b.
  task automatic run_seq(input string tag, input int stall, input int ign_a,
                         input int ign_b, input int e_cke, input int a0,
                         input int a1, input int a2, input int a3, input int a4,
                         input int e_done);
    int acc[5];
    int cod[5];
    int exp_acc[5];
    int exp_cod[5];
    int n_acc = 0;
    int cke_first = -1;
    int done_cyc = -1;
    int stall_cnt = 0;
    int hold_code = 0;
    bit bad_inv = 1'b0;
    bit bad_hold = 1'b0;
    exp_acc = '{a0, a1, a2, a3, a4};
    exp_cod = '{1, 2, 3, 4, 4};
    for (int k = 0; k < 5; k++) begin
      acc[k] = -1;
      cod[k] = -1;
    end
    cmd_ready  = 1'b1;
    init_start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      init_start = (c == ign_a || c == ign_b);
      if (c == 1) begin
        chk({tag, "_c1_busy"}, int'(o_busy), 1);
        chk({tag, "_c1_done"}, int'(o_done), 0);
        chk({tag, "_c1_cke"},  int'(o_cke),  0);
      end
      if ((o_busy && o_done) || (o_vld && !o_busy)) bad_inv = 1'b1;
      if (cke_first < 0 && o_cke) cke_first = c;
      if (o_vld) begin
        if (stall_cnt > 0 && int'(o_code) != hold_code) bad_hold = 1'b1;
        hold_code = int'(o_code);
        if (stall_cnt < stall) begin
          cmd_ready = 1'b0;
          stall_cnt++;
        end else begin
          cmd_ready = 1'b1;
          if (n_acc < 5) begin
            acc[n_acc] = c;
            cod[n_acc] = int'(o_code);
          end
          n_acc++;
          stall_cnt = 0;
        end
      end else begin
        cmd_ready = 1'b1;
        if (stall_cnt != 0) bad_hold = 1'b1;
      end
      if (o_done) begin
        done_cyc = c;
        break;
      end
    end
    init_start = 1'b0;
    cmd_ready  = 1'b1;
    chk({tag, "_cke_rise"}, cke_first, e_cke);
    chk({tag, "_n_acc"}, n_acc, 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s_acc%0d_cyc", tag, k), acc[k], exp_acc[k]);
      chk($sformatf("%s_acc%0d_code", tag, k), cod[k], exp_cod[k]);
    end
    chk({tag, "_done_cyc"}, done_cyc, e_done);
    chk({tag, "_invariants"}, int'(bad_inv), 0);
    chk({tag, "_hold_stable"}, int'(bad_hold), 0);
    chk({tag, "_end_busy"}, int'(o_busy), 0);
    chk({tag, "_end_vld"}, int'(o_vld), 0);
    chk({tag, "_end_cke"}, int'(o_cke), 1);
  endtask

  initial begin
    // Reset with init_start also high: reset must win.
    rst = 1'b1;
    init_start = 1'b1;
    tick();
    tick();
    chk("rst_cke",  int'(o_cke),  0);
    chk("rst_vld",  int'(o_vld),  0);
    chk("rst_code", int'(o_code), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    init_start = 1'b0;
    rst = 1'b0;
    tick();
    chk("idle_busy", int'(o_busy), 0);

    // Normal run, then re-init straight from DONE.
    run_seq("s1_normal", 0, -1, -1, 9, 13, 17, 20, 23, 29, 35);
    chk("s1_done_held", int'(o_done), 1);
    run_seq("s5_reinit", 0, -1, -1, 9, 13, 17, 20, 23, 29, 35);

    // Starts during CKE_WAIT (cycle 10) and ISS_MRS (cycle 20) are ignored.
    run_seq("s4_ignore", 0, 10, 20, 9, 13, 17, 20, 23, 29, 35);

    // Five stall cycles on every issue.
    run_seq("s2_bp", 5, -1, -1, 9, 18, 27, 35, 43, 54, 60);

    // Abort during W_RFC (cycle 26), then a fresh sequence.
    init_start = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      tick();
      init_start = 1'b0;
    end
    chk("s3_mid_busy", int'(o_busy), 1);
    chk("s3_mid_cke",  int'(o_cke),  1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s3_rst_cke",  int'(o_cke),  0);
    chk("s3_rst_vld",  int'(o_vld),  0);
    chk("s3_rst_code", int'(o_code), 0);
    chk("s3_rst_busy", int'(o_busy), 0);
    chk("s3_rst_done", int'(o_done), 0);
    tick();
    tick();
    chk("s3_stays_idle", int'(o_busy), 0);
    run_seq("s3_restart", 0, -1, -1, 9, 13, 17, 20, 23, 29, 35);

    // Zero TRP/TMRD: each of those waits lasts one cycle.
    sel = 1'b1;
    tick();
    chk("s6_idle", int'(o_busy), 0);
    run_seq("s6_zero", 0, -1, -1, 9, 13, 15, 17, 19, 25, 31);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
